// File: rtl/axis_fifo_arbiter_if.sv
// axis_fifo_arbiter_if: bundles the S_COUNT input streams, the merged output
// stream and the grant/status observation signals of axis_fifo_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface axis_fifo_arbiter_if #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = (DATA_WIDTH / 8),
  parameter int USER_WIDTH = 1
);
  localparam int IDX_W = $clog2(S_COUNT);

  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata;
  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [S_COUNT-1:0]            s_axis_tvalid;
  logic [S_COUNT-1:0]            s_axis_tready;
  logic [S_COUNT-1:0]            s_axis_tlast;
  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser;

  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic [KEEP_WIDTH-1:0]         m_axis_tkeep;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;
  logic                          m_axis_tlast;
  logic [USER_WIDTH-1:0]         m_axis_tuser;

  logic                          grant_valid;
  logic [IDX_W-1:0]              grant_index;
  logic                          status_timeout;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  m_axis_tready,
    output grant_valid, grant_index, status_timeout
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output m_axis_tready,
    input  grant_valid, grant_index, status_timeout
  );
endinterface

// File: rtl/axis_fifo_arbiter.sv
// axis_fifo_arbiter: frame-aware round-robin merge of S_COUNT AXI-Stream
// sources into one registered output stream feeding a shared FIFO.
// A grant is held from the first beat until the tlast beat is accepted;
// every frame costs one idle arbitration cycle.
// Optional feature: define AXIS_FIFO_ARB_TIMEOUT_EN to abort a granted frame
// whose source stalls for TIMEOUT cycles (abort beat + drop of the remainder).
module axis_fifo_arbiter #(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8) ? 1 : 0,
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int USER_WIDTH  = 1,
  parameter int TIMEOUT     = 1024
) (
  input  logic                clk,
  input  logic                rst,
  axis_fifo_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(S_COUNT);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t                r_state;
  logic                  r_grant_valid;
  logic [IDX_W-1:0]      r_grant_index;
  logic [IDX_W-1:0]      r_last_ptr;
  logic                  r_m_tvalid;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic [KEEP_WIDTH-1:0] r_m_tkeep;
  logic                  r_m_tlast;
  logic [USER_WIDTH-1:0] r_m_tuser;

  logic [S_COUNT-1:0]    w_drop;
  logic [S_COUNT-1:0]    w_req;
  logic                  w_any_req;
  logic [IDX_W-1:0]      w_pick_index;
  logic [S_COUNT-1:0]    w_s_tready;
  logic                  w_out_ready;
  logic                  w_accept;
  logic                  w_sel_tvalid;
  logic                  w_sel_tlast;
  logic [DATA_WIDTH-1:0] w_sel_tdata;
  logic [KEEP_WIDTH-1:0] w_sel_tkeep;
  logic [USER_WIDTH-1:0] w_sel_tuser;

  // The output register can take a new beat when it is empty or being drained.
  assign w_out_ready  = bus.m_axis_tready | ~r_m_tvalid;
  assign w_sel_tvalid = bus.s_axis_tvalid[r_grant_index];
  assign w_sel_tlast  = bus.s_axis_tlast[r_grant_index];
  assign w_sel_tdata  = bus.s_axis_tdata[int'(r_grant_index) * DATA_WIDTH +: DATA_WIDTH];
  assign w_sel_tkeep  = bus.s_axis_tkeep[int'(r_grant_index) * KEEP_WIDTH +: KEEP_WIDTH];
  assign w_sel_tuser  = bus.s_axis_tuser[int'(r_grant_index) * USER_WIDTH +: USER_WIDTH];
  assign w_accept     = (r_state == ST_GRANT) & w_sel_tvalid & w_out_ready;
  assign w_req        = bus.s_axis_tvalid & ~w_drop;
  assign w_any_req    = |w_req;

  assign bus.s_axis_tready = w_s_tready;
  assign bus.m_axis_tvalid = r_m_tvalid;
  assign bus.m_axis_tdata  = r_m_tdata;
  assign bus.m_axis_tkeep  = r_m_tkeep;
  assign bus.m_axis_tlast  = r_m_tlast;
  assign bus.m_axis_tuser  = r_m_tuser;
  assign bus.grant_valid   = r_grant_valid;
  assign bus.grant_index   = r_grant_index;

`ifdef AXIS_FIFO_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0]    r_to_cnt;
  logic [S_COUNT-1:0] r_drop;
  logic               r_status_timeout;
  logic               w_timeout_fire;

  // Abort fires on the TIMEOUT-th consecutive stall cycle, once the output
  // register is free to take the abort beat.
  assign w_timeout_fire = (r_state == ST_GRANT) & ~w_sel_tvalid & w_out_ready &
                          (r_to_cnt >= TO_W'(TIMEOUT - 1));
  assign w_drop             = r_drop;
  assign bus.status_timeout = r_status_timeout;

  // Stall counter for the granted stream and per-stream drop flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= {TO_W{1'b0}};
      r_drop   <= {S_COUNT{1'b0}};
    end else begin
      if ((r_state != ST_GRANT) || w_accept || w_timeout_fire) begin
        r_to_cnt <= {TO_W{1'b0}};
      end else if (!w_sel_tvalid && (r_to_cnt < TO_W'(TIMEOUT - 1))) begin
        r_to_cnt <= r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
      end
      for (int i = 0; i < S_COUNT; i++) begin
        if (w_timeout_fire && (r_grant_index == IDX_W'(i))) begin
          r_drop[i] <= 1'b1;
        end else if (r_drop[i] && bus.s_axis_tvalid[i] && bus.s_axis_tlast[i]) begin
          r_drop[i] <= 1'b0;
        end
      end
    end
  end
`else
  assign w_drop             = {S_COUNT{1'b0}};
  assign bus.status_timeout = 1'b0;
`endif

  // Round-robin pick: nearest requester after the last-granted index, wrapping.
  always_comb begin
    logic [IDX_W-1:0] v_idx;
    v_idx        = {IDX_W{1'b0}};
    w_pick_index = r_last_ptr;
    for (int k = S_COUNT; k >= 1; k--) begin
      v_idx        = IDX_W'((int'(r_last_ptr) + k) % S_COUNT);
      w_pick_index = w_req[v_idx] ? v_idx : w_pick_index;
    end
  end

  // Only the granted stream sees ready; dropping streams are always sunk.
  always_comb begin
    w_s_tready = w_drop;
    if (r_state == ST_GRANT) begin
      w_s_tready[r_grant_index] = w_out_ready;
    end else begin
      w_s_tready = w_drop;
    end
  end

  // Arbitration FSM with the output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_grant_valid <= 1'b0;
      r_grant_index <= {IDX_W{1'b0}};
      r_last_ptr    <= IDX_W'(S_COUNT - 1);
      r_m_tvalid    <= 1'b0;
      r_m_tdata     <= {DATA_WIDTH{1'b0}};
      r_m_tkeep     <= {KEEP_WIDTH{1'b0}};
      r_m_tlast     <= 1'b0;
      r_m_tuser     <= {USER_WIDTH{1'b0}};
`ifdef AXIS_FIFO_ARB_TIMEOUT_EN
      r_status_timeout <= 1'b0;
`endif
    end else begin
`ifdef AXIS_FIFO_ARB_TIMEOUT_EN
      r_status_timeout <= 1'b0;
`endif
      if (w_out_ready) begin
        r_m_tvalid <= w_accept;
        r_m_tdata  <= w_sel_tdata;
        r_m_tkeep  <= (KEEP_ENABLE != 0) ? w_sel_tkeep : {KEEP_WIDTH{1'b1}};
        r_m_tlast  <= w_sel_tlast;
        r_m_tuser  <= w_sel_tuser;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state       <= ST_GRANT;
            r_grant_valid <= 1'b1;
            r_grant_index <= w_pick_index;
            r_last_ptr    <= w_pick_index;
          end
        end
        ST_GRANT: begin
          if (w_accept && w_sel_tlast) begin
            r_state       <= ST_IDLE;
            r_grant_valid <= 1'b0;
          end
`ifdef AXIS_FIFO_ARB_TIMEOUT_EN
          else if (w_timeout_fire) begin
            r_state          <= ST_IDLE;
            r_grant_valid    <= 1'b0;
            r_status_timeout <= 1'b1;
            r_m_tvalid       <= 1'b1;
            r_m_tdata        <= {DATA_WIDTH{1'b0}};
            r_m_tkeep        <= {KEEP_WIDTH{1'b0}};
            r_m_tlast        <= 1'b1;
            r_m_tuser        <= {USER_WIDTH{1'b1}};
          end
`endif
        end
        default: begin
          r_state       <= ST_IDLE;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axis_fifo_arbiter.sv
// Directed bench for axis_fifo_arbiter: small per-stream frame sources,
// an output/grant monitor sampled on the falling edge, and one task per scenario.
module tb_axis_fifo_arbiter;
  localparam int S = 4;
`ifdef AXIS_FIFO_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic clk;
  logic rst;

  axis_fifo_arbiter_if #(.S_COUNT(S), .DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1)) bus ();

  axis_fifo_arbiter #(
    .S_COUNT(S), .DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc;
  logic [3:0] act, pause, acc;
  int pos[S], len[S], frames[S], acc_cnt[S];
  logic [7:0] dat[S];
  logic rdy_toggle;
  logic prev_gv;
  logic [7:0] q_data[$];
  logic q_last[$];
  logic q_user[$];
  int q_cyc[$];
  int q_gnt[$];

  task automatic drive_src();
    for (int i = 0; i < S; i++) begin
      bus.s_axis_tvalid[i]        = act[i] && !pause[i] && (frames[i] > 0);
      bus.s_axis_tdata[i*8 +: 8]  = dat[i];
      bus.s_axis_tlast[i]         = (pos[i] == len[i] - 1);
      bus.s_axis_tkeep[i]         = 1'b1;
      bus.s_axis_tuser[i]         = 1'b0;
    end
  endtask

  task automatic src_init();
    act = 4'b0000; pause = 4'b0000; rdy_toggle = 1'b0;
    for (int i = 0; i < S; i++) begin
      pos[i] = 0; len[i] = 1; frames[i] = 0; acc_cnt[i] = 0; dat[i] = 8'h00;
    end
    q_data.delete(); q_last.delete(); q_user.delete(); q_cyc.delete(); q_gnt.delete();
    cyc = 0;
    prev_gv = bus.grant_valid;
    bus.m_axis_tready = 1'b1;
  endtask

  // One clock: monitor at the falling edge, then advance sources after the rising edge.
  task automatic clk_cycle();
    @(negedge clk);
    acc = bus.s_axis_tvalid & bus.s_axis_tready;
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      q_data.push_back(bus.m_axis_tdata); q_last.push_back(bus.m_axis_tlast);
      q_user.push_back(bus.m_axis_tuser[0]); q_cyc.push_back(cyc);
    end
    if (bus.grant_valid && !prev_gv) q_gnt.push_back(int'(bus.grant_index));
    prev_gv = bus.grant_valid;
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < S; i++) begin
      if (acc[i]) begin
        dat[i]++; acc_cnt[i]++;
        if (pos[i] == len[i] - 1) begin pos[i] = 0; frames[i]--; end
        else pos[i]++;
      end
    end
    bus.m_axis_tready = rdy_toggle ? ~cyc[0] : 1'b1;
    drive_src();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_init(); drive_src();
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++; if (bus.m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", bus.m_axis_tvalid); end
    n_cmp++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rst_grant_valid: got %b want 0", bus.grant_valid); end
    n_cmp++; if (bus.grant_index !== 2'd0) begin n_fail++; $display("FAIL rst_grant_index: got %0d want 0", bus.grant_index); end
    n_cmp++; if (bus.status_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_status: got %b want 0", bus.status_timeout); end
    n_cmp++; if (bus.s_axis_tready !== 4'b0000) begin n_fail++; $display("FAIL rst_tready: got %b want 0000", bus.s_axis_tready); end
    rst = 1'b0;
    repeat (3) clk_cycle();
    n_cmp++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_grant: got %b want 0", bus.grant_valid); end
  endtask

  task automatic test_round_robin();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_d[10] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
    int exp_c[10] = '{2, 3, 5, 6, 8, 9, 11, 12, 14, 15};
    src_init();
    for (int i = 0; i < S; i++) begin
      act[i] = 1'b1; len[i] = 2; frames[i] = (i == 0) ? 2 : 1; dat[i] = 8'(i * 16);
    end
    drive_src();
    repeat (20) clk_cycle();
    n_cmp++; if (q_gnt.size() != 5) begin n_fail++; $display("FAIL rr_grant_count: got %0d want 5", q_gnt.size()); end
    for (int k = 0; k < 5 && k < q_gnt.size(); k++) begin
      n_cmp++; if (q_gnt[k] !== exp_g[k]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d want %0d", k, q_gnt[k], exp_g[k]); end
    end
    n_cmp++; if (q_data.size() != 10) begin n_fail++; $display("FAIL rr_beat_count: got %0d want 10", q_data.size()); end
    for (int k = 0; k < 10 && k < q_data.size(); k++) begin
      n_cmp++; if (q_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", k, q_data[k], exp_d[k]); end
      n_cmp++; if (q_last[k] !== k[0]) begin n_fail++; $display("FAIL rr_last[%0d]: got %b want %b", k, q_last[k], k[0]); end
      n_cmp++; if (q_cyc[k] !== exp_c[k]) begin n_fail++; $display("FAIL rr_cycle[%0d]: got %0d want %0d", k, q_cyc[k], exp_c[k]); end
    end
  endtask

  task automatic test_single_beat();
    src_init();
    act[2] = 1'b1; len[2] = 1; frames[2] = 1; dat[2] = 8'hA5;
    drive_src();
    n_cmp++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL sb_gv_c0: got %b want 0", bus.grant_valid); end
    clk_cycle();
    n_cmp++; if (bus.grant_valid !== 1'b1) begin n_fail++; $display("FAIL sb_gv_c1: got %b want 1", bus.grant_valid); end
    n_cmp++; if (bus.grant_index !== 2'd2) begin n_fail++; $display("FAIL sb_gidx: got %0d want 2", bus.grant_index); end
    n_cmp++; if (bus.m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL sb_tvalid_c1: got %b want 0", bus.m_axis_tvalid); end
    clk_cycle();
    n_cmp++; if (bus.m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL sb_tvalid_c2: got %b want 1", bus.m_axis_tvalid); end
    n_cmp++; if (bus.m_axis_tdata !== 8'hA5) begin n_fail++; $display("FAIL sb_tdata: got %h want a5", bus.m_axis_tdata); end
    n_cmp++; if (bus.m_axis_tlast !== 1'b1) begin n_fail++; $display("FAIL sb_tlast: got %b want 1", bus.m_axis_tlast); end
    n_cmp++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL sb_gv_c2: got %b want 0", bus.grant_valid); end
    repeat (3) clk_cycle();
    n_cmp++; if (q_data.size() != 1) begin n_fail++; $display("FAIL sb_beat_count: got %0d want 1", q_data.size()); end
  endtask

  task automatic test_backpressure();
    logic pv, pr, pl;
    logic [7:0] pd;
    src_init();
    rdy_toggle = 1'b1;
    act[1] = 1'b1; len[1] = 4; frames[1] = 1; dat[1] = 8'h40;
    drive_src();
    for (int c = 0; c < 14; c++) begin
      pv = bus.m_axis_tvalid; pr = bus.m_axis_tready; pd = bus.m_axis_tdata; pl = bus.m_axis_tlast;
      clk_cycle();
      if (pv && !pr) begin
        n_cmp++;
        if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== pd || bus.m_axis_tlast !== pl) begin
          n_fail++; $display("FAIL bp_hold c%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", cyc, bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, pd, pl);
        end
      end
    end
    rdy_toggle = 1'b0;
    bus.m_axis_tready = 1'b1;
    n_cmp++; if (q_data.size() != 4) begin n_fail++; $display("FAIL bp_beat_count: got %0d want 4", q_data.size()); end
    for (int k = 0; k < 4 && k < q_data.size(); k++) begin
      n_cmp++; if (q_data[k] !== 8'(8'h40 + k)) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", k, q_data[k], 8'(8'h40 + k)); end
      n_cmp++; if (q_last[k] !== (k == 3)) begin n_fail++; $display("FAIL bp_last[%0d]: got %b want %b", k, q_last[k], (k == 3)); end
    end
  endtask

  task automatic test_pause();
    logic [7:0] exp_d[5] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60};
    int pcnt = 0;
    src_init();
    act[0] = 1'b1; len[0] = 4; frames[0] = 1; dat[0] = 8'h50;
    len[3] = 1; frames[3] = 1; dat[3] = 8'h60;
    drive_src();
    for (int c = 0; c < 25; c++) begin
      clk_cycle();
      if (cyc == 2) act[3] = 1'b1;
      if (acc_cnt[0] == 2 && pcnt < 5) begin pause[0] = 1'b1; pcnt++; end
      else pause[0] = 1'b0;
      drive_src();
      #1;
      if (pause[0]) begin
        n_cmp++; if (bus.grant_valid !== 1'b1) begin n_fail++; $display("FAIL pause_gv c%0d: got %b want 1", cyc, bus.grant_valid); end
        n_cmp++; if (bus.grant_index !== 2'd0) begin n_fail++; $display("FAIL pause_gidx c%0d: got %0d want 0", cyc, bus.grant_index); end
        n_cmp++; if (bus.s_axis_tready[3] !== 1'b0) begin n_fail++; $display("FAIL pause_rdy3 c%0d: got %b want 0", cyc, bus.s_axis_tready[3]); end
      end
    end
    n_cmp++; if (pcnt != 5) begin n_fail++; $display("FAIL pause_cycles: got %0d want 5", pcnt); end
    n_cmp++; if (q_gnt.size() != 2) begin n_fail++; $display("FAIL pause_grant_count: got %0d want 2", q_gnt.size()); end
    if (q_gnt.size() == 2) begin
      n_cmp++; if (q_gnt[0] !== 0 || q_gnt[1] !== 3) begin n_fail++; $display("FAIL pause_grant_order: got %0d,%0d want 0,3", q_gnt[0], q_gnt[1]); end
    end
    n_cmp++; if (q_data.size() != 5) begin n_fail++; $display("FAIL pause_beat_count: got %0d want 5", q_data.size()); end
    for (int k = 0; k < 5 && k < q_data.size(); k++) begin
      n_cmp++; if (q_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL pause_data[%0d]: got %h want %h", k, q_data[k], exp_d[k]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    src_init();
    act[1] = 1'b1; len[1] = 4; frames[1] = 1; dat[1] = 8'h70;
    drive_src();
    for (int c = 0; c < 10 && acc_cnt[1] < 1; c++) clk_cycle();
    n_cmp++; if (acc_cnt[1] != 1) begin n_fail++; $display("FAIL rm_first_beat: got %0d beats want 1", acc_cnt[1]); end
    rst = 1'b1;
    clk_cycle();
    n_cmp++; if (bus.m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rm_tvalid: got %b want 0", bus.m_axis_tvalid); end
    n_cmp++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rm_gv: got %b want 0", bus.grant_valid); end
    n_cmp++; if (bus.s_axis_tready !== 4'b0000) begin n_fail++; $display("FAIL rm_tready: got %b want 0000", bus.s_axis_tready); end
    rst = 1'b0;
    src_init();
    act[1] = 1'b1; frames[1] = 1; dat[1] = 8'h81;
    act[2] = 1'b1; frames[2] = 1; dat[2] = 8'h82;
    drive_src();
    repeat (8) clk_cycle();
    n_cmp++; if (q_gnt.size() != 2) begin n_fail++; $display("FAIL rm_grant_count: got %0d want 2", q_gnt.size()); end
    if (q_gnt.size() == 2) begin
      n_cmp++; if (q_gnt[0] !== 1 || q_gnt[1] !== 2) begin n_fail++; $display("FAIL rm_grant_order: got %0d,%0d want 1,2", q_gnt[0], q_gnt[1]); end
    end
    n_cmp++; if (q_data.size() != 2) begin n_fail++; $display("FAIL rm_beat_count: got %0d want 2", q_data.size()); end
    if (q_data.size() == 2) begin
      n_cmp++; if (q_data[0] !== 8'h81 || q_data[1] !== 8'h82) begin n_fail++; $display("FAIL rm_data: got %h,%h want 81,82", q_data[0], q_data[1]); end
    end
  endtask

`ifdef AXIS_FIFO_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] exp_d[3] = '{8'h90, 8'h00, 8'hB0};
    logic exp_l[3] = '{1'b0, 1'b1, 1'b1};
    logic exp_u[3] = '{1'b0, 1'b1, 1'b0};
    int n_st = 0;
    src_init();
    act[1] = 1'b1; len[1] = 4; frames[1] = 1; dat[1] = 8'h90;
    act[2] = 1'b1; len[2] = 1; frames[2] = 1; dat[2] = 8'hB0;
    drive_src();
    for (int c = 0; c < 40; c++) begin
      clk_cycle();
      if (bus.status_timeout === 1'b1) n_st++;
      pause[1] = (acc_cnt[1] >= 1) && (n_st == 0);
      drive_src();
    end
    n_cmp++; if (n_st != 1) begin n_fail++; $display("FAIL to_status_pulses: got %0d want 1", n_st); end
    n_cmp++; if (frames[1] != 0) begin n_fail++; $display("FAIL to_sink: got %0d frames left want 0", frames[1]); end
    n_cmp++; if (q_gnt.size() != 2) begin n_fail++; $display("FAIL to_grant_count: got %0d want 2", q_gnt.size()); end
    if (q_gnt.size() == 2) begin
      n_cmp++; if (q_gnt[0] !== 1 || q_gnt[1] !== 2) begin n_fail++; $display("FAIL to_grant_order: got %0d,%0d want 1,2", q_gnt[0], q_gnt[1]); end
    end
    n_cmp++; if (q_data.size() != 3) begin n_fail++; $display("FAIL to_beat_count: got %0d want 3", q_data.size()); end
    for (int k = 0; k < 3 && k < q_data.size(); k++) begin
      n_cmp++;
      if (q_data[k] !== exp_d[k] || q_last[k] !== exp_l[k] || q_user[k] !== exp_u[k]) begin
        n_fail++; $display("FAIL to_beat[%0d]: got d=%h l=%b u=%b want d=%h l=%b u=%b", k, q_data[k], q_last[k], q_user[k], exp_d[k], exp_l[k], exp_u[k]);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.s_axis_tvalid = 4'b0000;
    bus.s_axis_tdata  = 32'h0;
    bus.s_axis_tkeep  = 4'b0000;
    bus.s_axis_tlast  = 4'b0000;
    bus.s_axis_tuser  = 4'b0000;
    bus.m_axis_tready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_round_robin();
    test_single_beat();
    test_backpressure();
    test_pause();
    test_reset_mid_frame();
`ifdef AXIS_FIFO_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
